scarv_cop_aes_lanes: RTL

Parametrised successor AES functional unit for the SCARV co-processor. Executes the sub (enc/encrot/dec/decrot) and mix (enc/dec) subclasses on LANES bytes per cycle, giving 4/LANES-cycle latency. Adds explicit step-counter clearing on completion, abort on ivalid withdrawal, restart on subclass change, and a busy flag. Sits beside the other co-processor functional units; writes back through the CPR byte-enable/data path.

---
 rtl/scarv_cop_aes_lanes_pkg.sv | 83 ++++++++
 rtl/scarv_cop_aes_lanes_mixlane.sv | 36 +++
 rtl/scarv_cop_aes_lanes.sv | 132 +++++++++++++
 3 files changed

// File: rtl/scarv_cop_aes_lanes_pkg.sv
// Shared definitions for the lane-parallel AES functional unit.
// Latency: n/a (types, constants and combinational GF(2^8) helpers only).
// Backpressure: n/a.
//
// Contents: one-hot subclass bit indices, step counter width, LANES
// legality check, GF(2^8) arithmetic and the forward/inverse S-box.
package scarv_cop_aes_lanes_pkg;

  // Bit positions inside the 15-bit one-hot id_subclass vector.
  localparam int AESSUB_ENC    = 0;
  localparam int AESSUB_ENCROT = 1;
  localparam int AESSUB_DEC    = 2;
  localparam int AESSUB_DECROT = 3;
  localparam int AESMIX_ENC    = 4;
  localparam int AESMIX_DEC    = 5;

  localparam int SUBCLASS_W = 15;
  localparam int AES_STEP_W = 2;

  // The six AES subclass bits pulled out of id_subclass.
  typedef struct packed {
    logic mix_dec;
    logic mix_enc;
    logic sub_decrot;
    logic sub_dec;
    logic sub_encrot;
    logic sub_enc;
  } aes_sel_t;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = gf_xtime(x);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  // Forward S-box = affine(inv(x)); inverse S-box = inv(affine^-1(x)).
  function automatic logic [7:0] aes_sbox(input logic [7:0] x, input logic inv);
    logic [7:0] y;
    logic [7:0] r;
    if (inv) begin
      y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      r = gf_inv(y);
    end else begin
      y = gf_inv(x);
      r = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    end
    return r;
  endfunction

endpackage

// File: rtl/scarv_cop_aes_lanes_mixlane.sv
// One output byte of AES MixColumns / InvMixColumns for a selected row.
// Latency: combinational.
// Backpressure: none.
//
// Ports: t0..t3 column bytes, row selects the output row (0..3),
// dec selects the inverse matrix, out is the resulting byte.
module scarv_cop_aes_lanes_mixlane
  import scarv_cop_aes_lanes_pkg::*;
(
  input  logic [7:0] t0,
  input  logic [7:0] t1,
  input  logic [7:0] t2,
  input  logic [7:0] t3,
  input  logic [1:0] row,
  input  logic       dec,
  output logic [7:0] out
);

  // Row 0 coefficients per column; other rows are this vector rotated right.
  logic [3:0][7:0] base;
  logic [3:0][7:0] tv;
  logic [1:0]      idx;

  assign base = dec ? 32'h090d_0b0e : 32'h0101_0302;
  assign tv   = {t3, t2, t1, t0};

  always_comb begin
    out = 8'h00;
    idx = 2'd0;
    for (int j = 0; j < 4; j++) begin
      idx = 2'(j) - row;
      out = out ^ gf_mul(base[idx], tv[j]);
    end
  end

endmodule

// File: rtl/scarv_cop_aes_lanes.sv
// AES sub/mix functional unit processing LANES bytes per cycle.
// Latency: 4/LANES cycles; aes_idone is combinational in the final step.
// Backpressure: none; aes_ivalid must be held until aes_idone, dropping it aborts.
//
// Ports: g_clk/g_resetn clock and async active-low reset; aes_ivalid,
// aes_rs1, aes_rs2, id_subclass (one-hot) describe the op; aes_idone,
// aes_busy report progress; aes_cpr_rd_ben/aes_cpr_rd_wdata write back.
module scarv_cop_aes_lanes #(
  parameter int LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        aes_ivalid,
  output logic        aes_idone,
  output logic        aes_busy,
  input  logic [31:0] aes_rs1,
  input  logic [31:0] aes_rs2,
  input  logic [14:0] id_subclass,
  output logic [3:0]  aes_cpr_rd_ben,
  output logic [31:0] aes_cpr_rd_wdata
);
  import scarv_cop_aes_lanes_pkg::*;

  localparam int STEPS = 4 / LANES;
  localparam logic [AES_STEP_W-1:0] LAST_STEP = AES_STEP_W'(STEPS - 1);

  if (!lanes_legal(LANES)) begin : g_lanes_check
    $error("scarv_cop_aes_lanes: LANES must be 1, 2 or 4");
  end

  aes_sel_t                sel;
  aes_sel_t                op_q;
  logic [AES_STEP_W-1:0]   step;
  logic [AES_STEP_W-1:0]   eff_step;
  logic [3:0][7:0]         tmp_q;
  logic [3:0][7:0]         merged;
  logic [3:0][7:0]         src_sub;
  logic [3:0][7:0]         src_mix;
  logic                    any_sel;
  logic                    is_mix;
  logic                    inv_op;
  logic                    rot_op;
  logic                    go;
  logic                    restart;
  logic                    last;
  logic [1:0]              lane_dst  [LANES];
  logic [7:0]              lane_byte [LANES];
  logic                    unused_bits;

  assign sel = '{mix_dec:    id_subclass[AESMIX_DEC],
                 mix_enc:    id_subclass[AESMIX_ENC],
                 sub_decrot: id_subclass[AESSUB_DECROT],
                 sub_dec:    id_subclass[AESSUB_DEC],
                 sub_encrot: id_subclass[AESSUB_ENCROT],
                 sub_enc:    id_subclass[AESSUB_ENC]};

  assign unused_bits = ^{id_subclass[14:6], aes_rs1[31:24], aes_rs2[7:0]};

  assign any_sel = |sel;
  assign is_mix  = sel.mix_enc | sel.mix_dec;
  assign inv_op  = sel.sub_dec | sel.sub_decrot;
  assign rot_op  = sel.sub_encrot | sel.sub_decrot;
  assign go      = aes_ivalid & any_sel;

  // A subclass change mid-op restarts from step 0 in the same cycle.
  assign restart  = (step != '0) && (sel != op_q);
  assign eff_step = restart ? '0 : step;
  assign last     = (eff_step == LAST_STEP);

  assign aes_idone        = go & last;
  assign aes_cpr_rd_ben   = {4{aes_idone}};
  assign aes_cpr_rd_wdata = go ? merged : 32'h0;

  assign src_sub = {aes_rs2[31:24], aes_rs1[23:16], aes_rs2[15:8], aes_rs1[7:0]};
  assign src_mix = {aes_rs2[31:24], aes_rs2[23:16], aes_rs1[15:8], aes_rs1[7:0]};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] k;
    logic [7:0] sb;
    logic [7:0] mx;

    assign k  = 2'(int'(eff_step) * LANES + l);
    assign sb = aes_sbox(src_sub[k], inv_op);

    scarv_cop_aes_lanes_mixlane u_mix (
      .t0  (src_mix[0]),
      .t1  (src_mix[1]),
      .t2  (src_mix[2]),
      .t3  (src_mix[3]),
      .row (k),
      .dec (sel.mix_dec),
      .out (mx)
    );

    assign lane_byte[l] = is_mix ? mx : sb;
    assign lane_dst[l]  = rot_op ? k + 2'd1 : k;
  end

  // Current lanes overlay the bytes gathered in earlier steps.
  always_comb begin
    merged = tmp_q;
    for (int l = 0; l < LANES; l++) begin
      merged[lane_dst[l]] = lane_byte[l];
    end
  end

  if (LANES == 4) begin : g_single
    logic unused_clk_rst;
    assign unused_clk_rst = g_clk & g_resetn;
    assign step     = '0;
    assign tmp_q    = '0;
    assign op_q     = '0;
    assign aes_busy = 1'b0;
  end else begin : g_multi
    always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
        step  <= '0;
        op_q  <= '0;
        tmp_q <= '0;
      end else if (!aes_ivalid) begin
        // Abort: partial bytes stay in tmp_q but every op rewrites all four.
        step <= '0;
      end else if (any_sel) begin
        step  <= last ? '0 : eff_step + 1'b1;
        tmp_q <= merged;
        if (eff_step == '0) op_q <= sel;
      end
    end
    assign aes_busy = (step != '0);
  end

endmodule
